// File: rtl/op_lut_event_cntr_regs.sv
// op_lut_event_cntr_regs: ring-attached event counters with multi-bit increments,
// wrap/saturate mode, clear-on-read, clear-all and sticky W1C overflow flags.
module op_lut_event_cntr_regs #(
    parameter int NUM_CNTRS         = 12,
    parameter int CNTR_WIDTH        = 32,
    parameter int INC_WIDTH         = 4,
    parameter int REG_ADDR_WIDTH    = 23,
    parameter int DATA_WIDTH        = 32,
    parameter int REG_OFF_BITS      = 6,
    parameter int BLOCK_TAG         = 0,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [REG_ADDR_WIDTH-1:0]       reg_addr_in,
    input  logic [DATA_WIDTH-1:0]           reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [REG_ADDR_WIDTH-1:0]       reg_addr_out,
    output logic [DATA_WIDTH-1:0]           reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
    input  logic [NUM_CNTRS-1:0]            event_valid,
    input  logic [NUM_CNTRS*INC_WIDTH-1:0]  event_inc,
    output logic                            ovf_any
);
    localparam int TAG_W = REG_ADDR_WIDTH - REG_OFF_BITS;
    localparam logic [REG_OFF_BITS-1:0] CTRL_OFF = REG_OFF_BITS'(NUM_CNTRS);
    localparam logic [REG_OFF_BITS-1:0] OVF_OFF  = REG_OFF_BITS'(NUM_CNTRS + 1);

    logic                         hit, rd, wr, clr_all;
    logic [REG_OFF_BITS-1:0]      off;
    logic [DATA_WIDTH-1:0]        rdata;
    logic [CNTR_WIDTH:0]          sum [NUM_CNTRS];
    logic [CNTR_WIDTH-1:0]        cntr_q [NUM_CNTRS];
    logic [CNTR_WIDTH-1:0]        cntr_d [NUM_CNTRS];
    logic [1:0]                   ctrl_q, ctrl_d;
    logic [NUM_CNTRS-1:0]         ovf_q, ovf_d;
    logic                         ovf_any_q;
    logic                         req_q, req_d, ack_q, ack_d, rw_q, rw_d;
    logic [REG_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;

    always_comb begin
        off     = reg_addr_in[REG_OFF_BITS-1:0];
        hit     = reg_req_in && !reg_ack_in && reg_addr_in[REG_ADDR_WIDTH-1:REG_OFF_BITS] == TAG_W'(BLOCK_TAG);
        rd      = hit && reg_rd_wr_L_in;
        wr      = hit && !reg_rd_wr_L_in;
        clr_all = wr && off == CTRL_OFF && reg_data_in[2];
        rdata   = off == CTRL_OFF ? DATA_WIDTH'(ctrl_q) :
                  off == OVF_OFF  ? DATA_WIDTH'(ovf_q)  : DATA_WIDTH'(32'hDEAD_BEEF);
        ctrl_d  = wr && off == CTRL_OFF ? reg_data_in[1:0] : ctrl_q;
        ovf_d   = ovf_q & ~(wr && off == OVF_OFF ? reg_data_in[NUM_CNTRS-1:0] : '0) & ~{NUM_CNTRS{clr_all}};
        for (int i = 0; i < NUM_CNTRS; i++) begin
            if (off == REG_OFF_BITS'(i)) rdata = DATA_WIDTH'(cntr_q[i]);
            // A new overflow wins over both W1C and clear-all on the same edge
            sum[i] = {1'b0, wr && off == REG_OFF_BITS'(i) ? reg_data_in[CNTR_WIDTH-1:0] :
                            (rd && off == REG_OFF_BITS'(i) && ctrl_q[1]) || clr_all ? '0 : cntr_q[i]}
                   + (event_valid[i] ? (CNTR_WIDTH+1)'(event_inc[i*INC_WIDTH +: INC_WIDTH]) : '0);
            cntr_d[i] = sum[i][CNTR_WIDTH] && ctrl_q[0] ? '1 : sum[i][CNTR_WIDTH-1:0];
            if (sum[i][CNTR_WIDTH]) ovf_d[i] = 1'b1;
        end
        req_d  = reg_req_in;
        ack_d  = reg_ack_in || hit;
        rw_d   = reg_rd_wr_L_in;
        addr_d = reg_addr_in;
        data_d = rd ? rdata : reg_data_in;
        src_d  = reg_src_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cntr_q    <= '{default: '0};
            ctrl_q    <= '0;
            ovf_q     <= '0;
            ovf_any_q <= 1'b0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            src_q     <= '0;
        end else begin
            cntr_q    <= cntr_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            ovf_any_q <= |ovf_q;
            req_q     <= req_d;
            ack_q     <= ack_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            src_q     <= src_d;
        end
    end

    assign reg_req_out     = req_q;
    assign reg_ack_out     = ack_q;
    assign reg_rd_wr_L_out = rw_q;
    assign reg_addr_out    = addr_q;
    assign reg_data_out    = data_q;
    assign reg_src_out     = src_q;
    assign ovf_any         = ovf_any_q;
endmodule

// File: tb/tb_op_lut_event_cntr_regs.sv
// tb_op_lut_event_cntr_regs: directed ring transactions checked against a queue of
// bench-computed expectations; 8-bit counters make wrap/saturate cheap to reach.
module tb_op_lut_event_cntr_regs;
    localparam int NC  = 12;
    localparam int CW  = 8;
    localparam int IW  = 4;
    localparam int TAG = 3;

    typedef struct {
        logic        req;
        logic        ack;
        logic        rw;
        logic [22:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
        string       tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
    logic [22:0]      reg_addr_in = '0;
    logic [31:0]      reg_data_in = '0;
    logic [1:0]       reg_src_in = '0;
    logic             reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0]      reg_addr_out;
    logic [31:0]      reg_data_out;
    logic [1:0]       reg_src_out;
    logic [NC-1:0]    event_valid = '0;
    logic [NC*IW-1:0] event_inc = '0;
    logic             ovf_any;
    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;

    op_lut_event_cntr_regs #(.NUM_CNTRS(NC), .CNTR_WIDTH(CW), .INC_WIDTH(IW), .BLOCK_TAG(TAG)) dut (
        .clk(clk), .reset(reset),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .event_valid(event_valid), .event_inc(event_inc), .ovf_any(ovf_any)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] A(input int tag, input int off);
        return (23'(tag) << 6) | 23'(off);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic req, input logic rd, input logic [22:0] addr,
                        input logic [31:0] wd, input logic ackin, input logic eack, input logic [31:0] edata);
        exp_t e;
        reg_req_in     = req;
        reg_ack_in     = ackin;
        reg_rd_wr_L_in = rd;
        reg_addr_in    = addr;
        reg_data_in    = wd;
        reg_src_in     = 2'($urandom_range(0, 3));
        sb.push_back('{req, eack, rd, addr, edata, reg_src_in, tag});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, ".ack"}, 32'(reg_ack_out), 32'(e.ack));
        chk({e.tag, ".data"}, reg_data_out, e.data);
        chk({e.tag, ".pass"}, 32'({reg_req_out, reg_rd_wr_L_out, reg_addr_out, reg_src_out}),
            32'({e.req, e.rw, e.addr, e.src}));
        reg_req_in = 1'b0;
        reg_ack_in = 1'b0;
    endtask

    task automatic rd(input string tag, input int off, input logic [31:0] edata);
        xfer(tag, 1'b1, 1'b1, A(TAG, off), 32'h0, 1'b0, 1'b1, edata);
    endtask

    task automatic wr(input string tag, input int off, input logic [31:0] wd);
        xfer(tag, 1'b1, 1'b0, A(TAG, off), wd, 1'b0, 1'b1, wd);
    endtask

    task automatic ev(input int i, input int inc);
        event_valid[i]          = 1'b1;
        event_inc[i*IW +: IW]   = IW'(inc);
    endtask

    task automatic ev_clr();
        event_valid = '0;
        event_inc   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reg_req_in  = 1'b1;
        reg_addr_in = A(TAG, 3);
        reg_data_in = 32'hFFFF_FFFF;
        idle(3);
        chk("rst.ack", 32'(reg_ack_out), 32'h0);
        chk("rst.req", 32'(reg_req_out), 32'h0);
        chk("rst.data", reg_data_out, 32'h0);
        chk("rst.ovf_any", 32'(ovf_any), 32'h0);
        reg_req_in = 1'b0;
        reset      = 1'b1;
        idle(1);

        rd("rd3_init", 3, 32'h0);

        ev(2, 5); idle(10); ev_clr();
        rd("cnt2_50", 2, 32'd50);
        xfer("acked_pass", 1'b1, 1'b1, A(TAG, 2), 32'h1234, 1'b1, 1'b1, 32'h1234);

        wr("wrap_ld", 0, 32'd250);
        ev(0, 9); idle(1); ev_clr();
        rd("wrap_cnt", 0, 32'd3);
        chk("wrap.ovf_any", 32'(ovf_any), 32'h1);
        rd("wrap_ovf", NC + 1, 32'h1);
        wr("w1c", NC + 1, 32'h1);
        rd("w1c_ovf", NC + 1, 32'h0);
        chk("w1c.ovf_any", 32'(ovf_any), 32'h0);

        wr("sat_ctrl", NC, 32'h1);
        wr("sat_ld", 0, 32'd250);
        ev(0, 9); idle(1); ev_clr();
        rd("sat_cnt", 0, 32'hFF);
        ev(0, 9); idle(3); ev_clr();
        rd("sat_hold", 0, 32'hFF);
        rd("sat_ovf", NC + 1, 32'h1);
        rd("sat_ctrl_rd", NC, 32'h1);
        wr("sat_w1c", NC + 1, 32'h1);

        wr("cor_ctrl", NC, 32'h2);
        wr("cor_ld", 5, 32'd7);
        ev(5, 4);
        rd("cor_rd1", 5, 32'd7);
        ev_clr();
        rd("cor_rd2", 5, 32'd4);
        rd("cor_rd3", 5, 32'd0);

        wr("ctrl0", NC, 32'h0);
        ev(1, 3);
        wr("wr_ev", 1, 32'd100);
        ev_clr();
        rd("wr_ev_rd", 1, 32'd103);

        rd("hole", NC + 5, 32'hDEAD_BEEF);
        xfer("tag_miss", 1'b1, 1'b1, A(1, 3), 32'hCAFE, 1'b0, 1'b0, 32'hCAFE);

        ev(3, 2);
        wr("clr_all", NC, 32'h4);
        ev_clr();
        rd("clr_cnt1", 1, 32'd0);
        rd("clr_cnt3", 3, 32'd2);
        rd("clr_ctrl", NC, 32'h0);

        wr("ovf4_ld", 4, 32'd250);
        ev(4, 9);
        wr("w1c_vs_ovf", NC + 1, 32'h10);
        ev_clr();
        rd("w1c_vs_ovf_rd", NC + 1, 32'h10);
        rd("ovf4_cnt", 4, 32'd3);

        xfer("no_req", 1'b0, 1'b1, A(TAG, 3), 32'h55, 1'b0, 1'b0, 32'h55);

        reg_req_in     = 1'b1;
        reg_rd_wr_L_in = 1'b1;
        reg_addr_in    = A(TAG, 4);
        @(posedge clk); #1;
        chk("mid.ack", 32'(reg_ack_out), 32'h1);
        chk("mid.data", reg_data_out, 32'd3);
        reset = 1'b0;
        #1;
        chk("mid_rst.ack", 32'(reg_ack_out), 32'h0);
        chk("mid_rst.req", 32'(reg_req_out), 32'h0);
        chk("mid_rst.ovf_any", 32'(ovf_any), 32'h0);
        reg_req_in = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);
        rd("post_rst_cnt4", 4, 32'd0);
        rd("post_rst_ovf", NC + 1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
